// File: rtl/shift_pkg.sv
// Shared opcode, control-code and state definitions for the shift sequencer.
package shift_pkg;

  localparam logic [2:0] OP_SLL     = 3'b000;
  localparam logic [2:0] OP_SRL     = 3'b001;
  localparam logic [2:0] OP_SRA     = 3'b010;
  localparam logic [2:0] OP_SLLV    = 3'b011;
  localparam logic [2:0] OP_SRLV    = 3'b100;
  localparam logic [2:0] OP_SRAV    = 3'b101;
  localparam logic [2:0] OP_SRAM    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  localparam logic [2:0] SC_NOP   = 3'b000;
  localparam logic [2:0] SC_LOAD  = 3'b001;
  localparam logic [2:0] SC_SHL   = 3'b010;
  localparam logic [2:0] SC_SHR_L = 3'b011;
  localparam logic [2:0] SC_SHR_A = 3'b100;

  localparam logic [1:0] SA_REGB  = 2'b00;
  localparam logic [1:0] SA_SHAMT = 2'b01;
  localparam logic [1:0] SA_MDR   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_WRITE    = 3'd4
  } state_t;

  typedef struct packed {
    logic       legal;
    logic       needs_mem;
    logic [1:0] shamt_sel;
    logic       shift_src_sel;
    logic [2:0] dir_code;
  } dec_t;

endpackage

// File: rtl/shift_op_decode.sv
// Combinational opcode decoder: legality, memory need, operand selects and shift direction.
module shift_op_decode
  import shift_pkg::*;
(
  input  logic [2:0] op,
  output dec_t       dec
);

  // Opcode to control-field lookup
  always_comb begin
    dec = '0;
    case (op)
      OP_SLL:  dec = '{legal: 1'b1, needs_mem: 1'b0, shamt_sel: SA_SHAMT, shift_src_sel: 1'b0, dir_code: SC_SHL};
      OP_SRL:  dec = '{legal: 1'b1, needs_mem: 1'b0, shamt_sel: SA_SHAMT, shift_src_sel: 1'b0, dir_code: SC_SHR_L};
      OP_SRA:  dec = '{legal: 1'b1, needs_mem: 1'b0, shamt_sel: SA_SHAMT, shift_src_sel: 1'b0, dir_code: SC_SHR_A};
      OP_SLLV: dec = '{legal: 1'b1, needs_mem: 1'b0, shamt_sel: SA_REGB,  shift_src_sel: 1'b1, dir_code: SC_SHL};
      OP_SRLV: dec = '{legal: 1'b1, needs_mem: 1'b0, shamt_sel: SA_REGB,  shift_src_sel: 1'b1, dir_code: SC_SHR_L};
      OP_SRAV: dec = '{legal: 1'b1, needs_mem: 1'b0, shamt_sel: SA_REGB,  shift_src_sel: 1'b1, dir_code: SC_SHR_A};
      OP_SRAM: dec = '{legal: 1'b1, needs_mem: 1'b1, shamt_sel: SA_MDR,   shift_src_sel: 1'b1, dir_code: SC_SHR_A};
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multicycle controller sequencing the shift unit through load, shift and write-back,
// with an optional bounded wait on a memory read for the shift amount.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       mem_ready,
  output logic [1:0] shamt_sel,
  output logic       shift_src_sel,
  output logic [2:0] shift_ctrl,
  output logic       mem_read,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam logic [8:0] TIMEOUT_LIMIT = 9'(MEM_TIMEOUT);

  state_t     state_r, state_s;
  logic [2:0] op_q_r;
  logic [7:0] cnt_r, cnt_s;
  logic       accept_s, err_s;
  logic [2:0] dec_op_s;
  dec_t       dec_s;

  logic [1:0] shamt_sel_r;
  logic       shift_src_sel_r;
  logic [2:0] shift_ctrl_r, shift_ctrl_s;
  logic       mem_read_r, mem_read_s;
  logic       reg_write_r, reg_write_s;
  logic       busy_r, busy_s;
  logic       done_r, done_s;
  logic       error_r;

  // In IDLE the live opcode is judged for acceptance; afterwards the latched one drives direction
  assign dec_op_s = (state_r == ST_IDLE) ? op : op_q_r;

  shift_op_decode u_decode (
    .op  (dec_op_s),
    .dec (dec_s)
  );

  // State register, counter, latched opcode/selects and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      op_q_r          <= OP_SLL;
      cnt_r           <= 8'd0;
      shamt_sel_r     <= SA_REGB;
      shift_src_sel_r <= 1'b0;
      shift_ctrl_r    <= SC_NOP;
      mem_read_r      <= 1'b0;
      reg_write_r     <= 1'b0;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      error_r         <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      shift_ctrl_r <= shift_ctrl_s;
      mem_read_r   <= mem_read_s;
      reg_write_r  <= reg_write_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      error_r      <= err_s;
      if (accept_s) begin
        op_q_r          <= op;
        shamt_sel_r     <= dec_s.shamt_sel;
        shift_src_sel_r <= dec_s.shift_src_sel;
      end else begin
        op_q_r          <= op_q_r;
        shamt_sel_r     <= shamt_sel_r;
        shift_src_sel_r <= shift_src_sel_r;
      end
    end
  end

  // Next-state, wait counter and error-pulse decision
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    accept_s = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && dec_s.legal) begin
          accept_s = 1'b1;
          state_s  = dec_s.needs_mem ? ST_MEM_WAIT : ST_LOAD;
        end else if (start) begin
          err_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MEM_WAIT: begin
        // mem_ready takes priority over a timeout landing on the same cycle
        if (mem_ready) begin
          state_s = ST_LOAD;
          cnt_s   = 8'd0;
        end else if (({1'b0, cnt_r} + 9'd1) >= TIMEOUT_LIMIT) begin
          state_s = ST_IDLE;
          cnt_s   = 8'd0;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      ST_LOAD:  state_s = ST_SHIFT;
      ST_SHIFT: state_s = ST_WRITE;
      ST_WRITE: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Moore output decode of the upcoming state, registered on the same edge as the state
  always_comb begin
    shift_ctrl_s = SC_NOP;
    mem_read_s   = 1'b0;
    reg_write_s  = 1'b0;
    busy_s       = 1'b1;
    done_s       = 1'b0;
    case (state_s)
      ST_IDLE:     busy_s       = 1'b0;
      ST_MEM_WAIT: mem_read_s   = 1'b1;
      ST_LOAD:     shift_ctrl_s = SC_LOAD;
      ST_SHIFT:    shift_ctrl_s = dec_s.dir_code;
      ST_WRITE: begin
        reg_write_s = 1'b1;
        done_s      = 1'b1;
      end
      default:     busy_s       = 1'b0;
    endcase
  end

  assign shamt_sel     = shamt_sel_r;
  assign shift_src_sel = shift_src_sel_r;
  assign shift_ctrl    = shift_ctrl_r;
  assign mem_read      = mem_read_r;
  assign reg_write     = reg_write_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign error         = error_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized bench for shift_sequencer: a per-operation cycle trace is predicted from the
// opcode classes and the memory-wait rules, then compared against the DUT every cycle.
module tb_shift_sequencer;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset, start, mem_ready;
  logic [2:0] op;
  logic [1:0] shamt_sel;
  logic       shift_src_sel;
  logic [2:0] shift_ctrl;
  logic       mem_read, reg_write, busy, done, error;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0] m_sa;
  logic       m_src;

  shift_sequencer #(.MEM_TIMEOUT(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .mem_ready     (mem_ready),
    .shamt_sel     (shamt_sel),
    .shift_src_sel (shift_src_sel),
    .shift_ctrl    (shift_ctrl),
    .mem_read      (mem_read),
    .reg_write     (reg_write),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  wire [10:0] obs = {shamt_sel, shift_src_sel, shift_ctrl, mem_read, reg_write, busy, done, error};

  task automatic check_vec(input string tag, input logic [10:0] got, input logic [10:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got sa/src/ctrl/mr/rw/busy/done/err=%b want %b", tag, got, want);
    end
  endtask

  function automatic logic [10:0] vec(input logic [1:0] sa, input logic src, input logic [2:0] sc,
                                      input logic mr, input logic rw, input logic bz,
                                      input logic dn, input logic er);
    return {sa, src, sc, mr, rw, bz, dn, er};
  endfunction

  // k: cycle (counted from 1 after accept) of the first mem_ready; > N means it never comes in time.
  // abort_at: cycle in which reset is asserted (0 = no abort).
  task automatic run_op(input logic [2:0] o, input int k, input int abort_at);
    logic [10:0] exp_q[$];
    logic [1:0]  sa;
    logic        src;
    logic [2:0]  dir;
    int          wait_cycles;
    int          ab;
    bit          timed_out;
    timed_out   = 1'b0;
    wait_cycles = 0;
    ab          = 0;
    if (o == 3'd7) begin
      exp_q.push_back(vec(m_sa, m_src, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    end else begin
      // Class by op/3: immediate, variable, memory-amount
      sa  = (o / 3 == 0) ? 2'b01 : ((o / 3 == 1) ? 2'b00 : 2'b10);
      src = (o / 3 != 0);
      dir = (o == 3'd6) ? 3'd4 : 3'(2 + (o % 3));
      m_sa  = sa;
      m_src = src;
      if (o == 3'd6) begin
        wait_cycles = (k >= 1 && k <= N) ? k : N;
        timed_out   = !(k >= 1 && k <= N);
        repeat (wait_cycles) exp_q.push_back(vec(sa, src, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
      end
      if (timed_out) begin
        exp_q.push_back(vec(sa, src, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
      end else begin
        exp_q.push_back(vec(sa, src, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(sa, src, dir,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
        exp_q.push_back(vec(sa, src, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
        exp_q.push_back(vec(sa, src, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      end
      if (abort_at > 0 && abort_at < exp_q.size()) begin
        ab = abort_at;
        while (exp_q.size() > ab) void'(exp_q.pop_back());
        exp_q.push_back(11'd0);
        m_sa  = 2'b00;
        m_src = 1'b0;
      end
    end
    start     = 1'b1;
    op        = o;
    mem_ready = 1'($urandom_range(0, 1));
    reset     = 1'b0;
    for (int c = 1; c <= exp_q.size(); c++) begin
      @(posedge clk);
      #1;
      check_vec($sformatf("op%0d k%0d ab%0d c%0d", o, k, ab, c), obs, exp_q[c-1]);
      if (c == exp_q.size()) begin
        start     = 1'b0;
        mem_ready = 1'b0;
        reset     = 1'b0;
      end else begin
        reset = (c == ab);
        start = 1'($urandom_range(0, 1));
        op    = 3'($urandom_range(0, 7));
        if (o == 3'd6 && c <= wait_cycles) mem_ready = (c == k);
        else mem_ready = 1'($urandom_range(0, 1));
      end
    end
  endtask

  initial begin
    int ro, rk, rab;
    reset     = 1'b1;
    start     = 1'b0;
    op        = 3'd0;
    mem_ready = 1'b0;
    m_sa      = 2'b00;
    m_src     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset", obs, 11'd0);
    reset = 1'b0;

    run_op(3'd0, 0, 0);      // SLL
    run_op(3'd5, 0, 0);      // SRAV with ignored restarts
    run_op(3'd6, 2, 0);      // SRAM, data in cycle 2
    run_op(3'd6, N, 0);      // ready on the timeout cycle wins
    run_op(3'd6, N + 5, 0);  // timeout
    run_op(3'd7, 0, 0);      // illegal
    run_op(3'd1, 0, 2);      // SRL reset during SHIFT
    run_op(3'd0, 0, 0);      // SLL after abort
    run_op(3'd6, 1, 0);
    run_op(3'd3, 0, 0);

    repeat (80) begin
      ro  = $urandom_range(0, 7);
      rk  = $urandom_range(1, N + 2);
      rab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_op(3'(ro), rk, rab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
